// File: rtl/sigma_delta_pkg.sv
// Shared definitions for the time-multiplexed sigma-delta scheduler:
// FSM state encoding and the first-order modulator update arithmetic.
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SCAN   = 2'd2,
        COMMIT = 2'd3
    } sd_state_t;

    // Next accumulator for a w-bit sample feeding a (w+1)-bit accumulator.
    // The two top bits of the feedback term both become ~acc[w-1], which
    // folds the quantiser feedback into the stored value. Operands are
    // carried in 64-bit containers (acc zero-extended, sample sign-extended).
    // The result is reduced modulo 2^(w+1), so w must be at most 62.
    function automatic logic [63:0] sd_next_acc(input logic [63:0] acc,
                                                input logic [63:0] smp,
                                                input int          w);
        logic [63:0] top_mask;
        logic [63:0] fb;
        logic [63:0] keep_mask;
        logic        nmsb;
        nmsb      = ~|((acc >> (w - 1)) & 64'd1);
        top_mask  = 64'd3 << (w - 1);
        fb        = (acc & ~top_mask) | (nmsb ? top_mask : 64'd0);
        keep_mask = (64'd1 << (w + 1)) - 64'd1;
        return (fb + smp) & keep_mask;
    endfunction

endpackage

// File: rtl/sigma_delta_update.sv
// Shared combinational sigma-delta update: one adder serves every channel.
module sigma_delta_update
    import sigma_delta_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH:0]   acc_new,
    output logic             bit_out
);

    logic [63:0]       acc_ext_s;
    logic [63:0]       smp_ext_s;
    logic [62-WIDTH:0] sum_unused_s;

    assign acc_ext_s = {{(63 - WIDTH){1'b0}}, acc};
    assign smp_ext_s = {{(64 - WIDTH){sample[WIDTH-1]}}, sample};
    assign {sum_unused_s, acc_new} = sd_next_acc(acc_ext_s, smp_ext_s, WIDTH);
    assign bit_out = acc_new[WIDTH];

endmodule

// File: rtl/sigma_delta_scheduler.sv
// Multi-channel first-order sigma-delta scheduler. A frame is a WAIT of
// div+1 cycles, one SCAN cycle per channel through the shared update, then
// COMMIT. The new output word and its strobe are registered on the last
// SCAN edge, so both are visible during the COMMIT cycle.
// Optional macro SD_SCHED_MUTE_EN adds a per-channel mute input that
// substitutes a zero sample in the channel's SCAN cycle.
module sigma_delta_scheduler
    import sigma_delta_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [DIV_WIDTH-1:0]      div,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [CHANNELS-1:0]       sd_out,
    output logic                      sd_strobe,
    output logic                      busy
`ifdef SD_SCHED_MUTE_EN
    ,
    input  logic [CHANNELS-1:0]       mute
`endif
);

    localparam int                   IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0]  ONE_HOT0  = CHANNELS'(1'b1);
    localparam logic [CHANNELS-1:0]  ALL_READY = {CHANNELS{1'b1}};

    sd_state_t             state_r;
    logic [DIV_WIDTH-1:0]  cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [WIDTH:0]        acc_r  [CHANNELS];
    logic [WIDTH-1:0]      hold_r [CHANNELS];
    logic [CHANNELS-1:0]   shadow_r;
    logic [CHANNELS-1:0]   sd_out_r;
    logic [CHANNELS-1:0]   ready_r;
    logic                  strobe_r;
    logic                  busy_r;

    logic [WIDTH:0]        acc_sel_s;
    logic [WIDTH-1:0]      smp_sel_s;
    logic [WIDTH:0]        acc_new_s;
    logic                  bit_new_s;
    logic [CHANNELS-1:0]   shadow_nx_s;

    // Route the scanned channel's accumulator and sample to the shared adder.
    always_comb begin
        acc_sel_s = acc_r[idx_r];
`ifdef SD_SCHED_MUTE_EN
        if (mute[idx_r]) begin
            smp_sel_s = {WIDTH{1'b0}};
        end else begin
            smp_sel_s = hold_r[idx_r];
        end
`else
        smp_sel_s = hold_r[idx_r];
`endif
    end

    // Shadow word with the scanned channel's fresh bit merged in.
    always_comb begin
        shadow_nx_s        = shadow_r;
        shadow_nx_s[idx_r] = bit_new_s;
    end

    sigma_delta_update #(
        .WIDTH (WIDTH)
    ) u_update (
        .acc     (acc_sel_s),
        .sample  (smp_sel_s),
        .acc_new (acc_new_s),
        .bit_out (bit_new_s)
    );

    // Capture producer samples whenever the channel handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                hold_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (in_valid[k] && ready_r[k]) begin
                    hold_r[k] <= in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Frame sequencer: rate counter, channel scan, accumulators and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {DIV_WIDTH{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            shadow_r <= {CHANNELS{1'b0}};
            sd_out_r <= {CHANNELS{1'b0}};
            ready_r  <= {CHANNELS{1'b0}};
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                acc_r[k] <= {(WIDTH + 1){1'b0}};
            end
        end else begin
            strobe_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    ready_r <= ALL_READY;
                    busy_r  <= run;
                    if (run) begin
                        state_r <= WAIT;
                        cnt_r   <= div;
                    end
                end
                WAIT: begin
                    if (cnt_r == {DIV_WIDTH{1'b0}}) begin
                        state_r <= SCAN;
                        idx_r   <= {IDX_W{1'b0}};
                        ready_r <= ~ONE_HOT0;
                    end else begin
                        cnt_r   <= cnt_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                        ready_r <= ALL_READY;
                    end
                end
                SCAN: begin
                    acc_r[idx_r] <= acc_new_s;
                    shadow_r     <= shadow_nx_s;
                    if (idx_r == LAST_IDX) begin
                        state_r  <= COMMIT;
                        sd_out_r <= shadow_nx_s;
                        strobe_r <= 1'b1;
                        ready_r  <= ALL_READY;
                    end else begin
                        idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        ready_r <= ~(ONE_HOT0 << (idx_r + {{(IDX_W-1){1'b0}}, 1'b1}));
                    end
                end
                COMMIT: begin
                    ready_r <= ALL_READY;
                    if (run) begin
                        state_r <= WAIT;
                        cnt_r   <= div;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= ALL_READY;
                end
            endcase
        end
    end

    assign in_ready  = ready_r;
    assign sd_out    = sd_out_r;
    assign sd_strobe = strobe_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sigma_delta_scheduler.sv
// Scoreboard bench for sigma_delta_scheduler (WIDTH=16, CHANNELS=4, div=3).
module tb_sigma_delta_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  div;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  sd_out;
    logic        sd_strobe;
    logic        busy;
`ifdef SD_SCHED_MUTE_EN
    logic [3:0]  mute = 4'h0;
`endif

    int total = 0;
    int bad = 0;
    int timeouts = 0;
    int cyc = 0;
    int m_acc [4];
    int m_s [4];
    logic [3:0] exp_q [$];
    logic [3:0] obs_q [$];
    int cyc_q [$];

    sigma_delta_scheduler #(.WIDTH(16), .CHANNELS(4), .DIV_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .div       (div),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .sd_out    (sd_out),
        .sd_strobe (sd_strobe),
        .busy      (busy)
`ifdef SD_SCHED_MUTE_EN
        ,
        .mute      (mute)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference modulator: feedback is r-32768 when acc bit15 is clear, else r.
    task automatic model_frame(output logic [3:0] e);
        int a, a15, r, fb, n;
        for (int k = 0; k < 4; k++) begin
            a   = m_acc[k];
            a15 = (a >>> 15) & 1;
            r   = a & 32'h7fff;
            fb  = (a15 != 0) ? r : r - 32768;
            n   = fb + m_s[k];
            if (n < -65536) n = n + 131072;
            if (n > 65535)  n = n - 131072;
            m_acc[k] = n;
            e[k] = (n < 0);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            m_s[k] = 0;
        end
    endtask

    task automatic load(input int ch, input int val);
        @(negedge clk);
        in_valid[ch] = 1'b1;
        in_data[ch*16 +: 16] = val[15:0];
        @(negedge clk);
        in_valid = 4'h0;
        m_s[ch] = val;
    endtask

    // Start frames from IDLE, push predictions, collect strobed outputs.
    task automatic run_frames(input int n);
        logic [3:0] e;
        int w;
        cyc_q.delete();
        run = 1'b1;
        for (int f = 0; f < n; f++) begin
            model_frame(e);
            exp_q.push_back(e);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (sd_strobe !== 1'b1 && w < 40);
            if (sd_strobe === 1'b1) begin
                obs_q.push_back(sd_out);
                cyc_q.push_back(cyc);
            end else begin
                obs_q.push_back(4'bxxxx);
                cyc_q.push_back(-1);
                timeouts++;
            end
            if (f == n - 1) run = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; div = 8'd3; in_valid = 4'h0; in_data = 64'h0;
        model_reset();
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL rst_ready: got %h want 0", in_ready); end
        total++; if (sd_out !== 4'h0) begin bad++; $display("FAIL rst_sd_out: got %h want 0", sd_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (sd_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe: got %b want 0", sd_strobe); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 4'hF) begin bad++; $display("FAIL post_rst_ready: got %h want f", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_samples();
        logic [3:0] e, o, c;
        int prev;
        @(negedge clk);
        run_frames(6);
        prev = -1;
        for (int f = 0; f < 6; f++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            c = (f % 2 == 0) ? 4'hF : 4'h0;
            total++; if (o !== e || o !== c) begin bad++; $display("FAIL zero_frame_%0d: got %h want %h", f, o, c); end
            if (f > 0) begin
                total++; if (cyc_q[f] - prev !== 9) begin bad++; $display("FAIL zero_period_%0d: got %0d want 9", f, cyc_q[f] - prev); end
            end
            prev = cyc_q[f];
        end
    endtask

    task automatic test_extremes();
        logic [3:0] e, o;
        load(0, 32767);
        load(1, -32768);
        run_frames(101);
        for (int f = 0; f < 101; f++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL ext_frame_%0d: got %h want %h", f, o, e); end
            total++; if (o[0] !== (f == 0) || o[1] !== 1'b1) begin bad++; $display("FAIL ext_bits_%0d: got ch0=%b ch1=%b want ch0=%b ch1=1", f, o[0], o[1], (f == 0)); end
        end
    endtask

    task automatic test_density();
        logic [3:0] e, o;
        int ones;
        ones = 0;
        load(2, 16384);
        run_frames(64);
        for (int f = 0; f < 64; f++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o[2] === 1'b1) ones++;
            total++; if (o !== e) begin bad++; $display("FAIL dens_frame_%0d: got %h want %h", f, o, e); end
        end
        total++; if (ones < 15 || ones > 17) begin bad++; $display("FAIL dens_count: got %0d want 15..17", ones); end
    endtask

    task automatic test_ready_window();
        logic [3:0] e, o;
        logic exp_r;
        int w;
        rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        load(1, 32767);
        run_frames(3);
        for (int f = 0; f < 3; f++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL rdy_pre_%0d: got %h want %h", f, o, e); end
        end
        @(negedge clk);
        in_valid[1] = 1'b1; in_data[31:16] = 16'h7fff; run = 1'b1;
        model_frame(e); exp_q.push_back(e);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            exp_r = (j == 6) ? 1'b0 : 1'b1;
            total++; if (in_ready[1] !== exp_r) begin bad++; $display("FAIL rdy_cycle_%0d: got %b want %b", j, in_ready[1], exp_r); end
            if (j == 6) in_data[31:16] = 16'h8000;
            if (j == 8) in_valid[1] = 1'b0;
        end
        total++; if (sd_strobe !== 1'b1) begin bad++; $display("FAIL rdy_strobe: got %b want 1", sd_strobe); end
        e = exp_q.pop_front();
        total++; if (sd_out !== e) begin bad++; $display("FAIL rdy_frame_a: got %h want %h", sd_out, e); end
        @(negedge clk);
        run = 1'b0;
        m_s[1] = -32768;
        model_frame(e); exp_q.push_back(e);
        w = 0;
        do begin @(negedge clk); w++; end while (sd_strobe !== 1'b1 && w < 40);
        e = exp_q.pop_front();
        total++; if (sd_strobe !== 1'b1 || sd_out !== e) begin bad++; $display("FAIL rdy_frame_b: got %h strobe=%b want %h", sd_out, sd_strobe, e); end
    endtask

    task automatic test_run_drop();
        logic [3:0] e;
        int w;
        @(negedge clk);
        run = 1'b1;
        model_frame(e); exp_q.push_back(e);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j == 7) run = 1'b0;
        end
        e = exp_q.pop_front();
        total++; if (sd_strobe !== 1'b1 || sd_out !== e) begin bad++; $display("FAIL drop_commit: got %h strobe=%b want %h", sd_out, sd_strobe, e); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || sd_strobe !== 1'b0) begin bad++; $display("FAIL drop_idle: got busy=%b strobe=%b want 0 0", busy, sd_strobe); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if (sd_out !== e) begin bad++; $display("FAIL drop_hold_%0d: got %h want %h", j, sd_out, e); end
        end
        run = 1'b1;
        model_frame(e); exp_q.push_back(e);
        w = 0;
        do begin @(negedge clk); w++; end while (sd_strobe !== 1'b1 && w < 40);
        run = 1'b0;
        total++; if (w !== 9) begin bad++; $display("FAIL drop_restart: got %0d cycles want 9", w); end
        e = exp_q.pop_front();
        total++; if (sd_out !== e) begin bad++; $display("FAIL drop_restart_out: got %h want %h", sd_out, e); end
    endtask

    task automatic test_async_reset();
        logic [3:0] e, o, c;
        for (int k = 0; k < 4; k++) load(k, -32768);
        run_frames(1);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++; if (o !== e || o !== 4'hF) begin bad++; $display("FAIL ares_pre: got %h want f", o); end
        @(negedge clk);
        run = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (sd_out !== 4'h0) begin bad++; $display("FAIL ares_sd_out: got %h want 0", sd_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ares_busy: got %b want 0", busy); end
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL ares_ready: got %h want 0", in_ready); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(3);
        for (int f = 0; f < 3; f++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            c = (f % 2 == 0) ? 4'hF : 4'h0;
            total++; if (o !== e || o !== c) begin bad++; $display("FAIL ares_frame_%0d: got %h want %h", f, o, c); end
            if (f > 0) begin
                total++; if (cyc_q[f] - cyc_q[f-1] !== 9) begin bad++; $display("FAIL ares_period_%0d: got %0d want 9", f, cyc_q[f] - cyc_q[f-1]); end
            end
        end
    endtask

    task automatic test_no_timeouts();
        total++; if (timeouts !== 0) begin bad++; $display("FAIL timeouts: got %0d want 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_zero_samples();
        test_extremes();
        test_density();
        test_ready_window();
        test_run_drop();
        test_async_reset();
        test_no_timeouts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sigma_delta_scheduler.md
Name: sigma_delta_scheduler

Overview:
Time-multiplexed controller that shares one first-order sigma-delta update datapath across CHANNELS independent channels. A programmable rate counter paces modulation frames. Each frame the block sequences every channel through the shared adder, then publishes all channel output bits together. It sits between sample producers (valid/ready) and pin-level 1-bit outputs such as PWM/DAC pins.

Parameters:
WIDTH, 16, signed sample width; each accumulator is WIDTH+1 bits
CHANNELS, 4, number of modulated channels (>=1)
DIV_WIDTH, 8, width of frame-rate divider input

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = generate frames, 0 = stop after current frame
div  in  DIV_WIDTH  WAIT length minus 1; sampled at each WAIT reload
in_valid  in  CHANNELS  per-channel sample valid
in_data  in  CHANNELS*WIDTH  signed samples, channel k at bits [k*WIDTH +: WIDTH]
in_ready  out  CHANNELS  per-channel ready
sd_out  out  CHANNELS  modulated bits, updated only at COMMIT
sd_strobe  out  1  one-cycle pulse on the cycle sd_out changes
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE, divider counter 0, scan index 0, all accumulators 0, all held samples 0, sd_out 0, shadow bits 0, sd_strobe 0, busy 0.
- Held sample per channel: loaded from in_data when in_valid[k] && in_ready[k]; holds indefinitely otherwise; the same sample is reused every frame until replaced.
- in_ready[k] = 1 except in SCAN while scan index == k, where it is 0. Reset value: 1 after release, 0 during reset.
- FSM:
  IDLE: run=1 -> WAIT, counter <= div.
  WAIT: counter decrements each cycle; at counter==0 -> SCAN, index <= 0.
  SCAN: one channel per cycle, index 0..CHANNELS-1; after index CHANNELS-1 -> COMMIT.
  COMMIT: sd_out <= shadow, sd_strobe=1. Then run=1 -> WAIT, counter <= div; run=0 -> IDLE.
- run is checked only in IDLE and COMMIT. Deasserting run mid-frame completes the frame. sd_out holds its value in IDLE.
- Frame period: div+1 (WAIT) + CHANNELS (SCAN) + 1 (COMMIT) = div+CHANNELS+2 cycles. A div change affects the next WAIT only.
- Channel update in its SCAN cycle, with acc = stored accumulator (WIDTH+1 bits, two's complement) and s = held sample:
  - acc_new = signed({~acc[WIDTH-1], ~acc[WIDTH-1], acc[WIDTH-2:0]}) + sign-extended s, modulo 2^(WIDTH+1).
  - Store acc_new; shadow[k] <= acc_new[WIDTH].
  - Output polarity: 1 = negative. Density of 1s is (2^(WIDTH-1) - s) / 2^WIDTH.
- Only one adder instance exists, muxed by scan index.
- A load on a channel not currently in SCAN is visible at that channel's next SCAN slot, including later in the same frame.

Optional Feature:
SD_SCHED_MUTE_EN
- Defined: adds input port mute [CHANNELS]. A muted channel uses 0 instead of its held sample in SCAN, giving a 50% density idle tone. Its accumulator keeps running and its held sample and handshake are unaffected. mute is sampled in the channel's SCAN cycle.
- Undefined: no mute port; all channels always use their held samples.

Decomposition:
- Package sigma_delta_pkg: state enum (IDLE, WAIT, SCAN, COMMIT) and a function computing the feedback-plus-input next accumulator value, parameterised by width.
- One natural sub-module: sigma_delta_update, the combinational shared update (acc, sample -> acc_new, bit). The scheduler owns the FSM, counter, storage arrays and handshake.

Test Plan:
All tests use WIDTH=16, CHANNELS=4, div=3 (frame period 9 cycles) unless noted.
1. All samples 0, run=1 -> sd_strobe every 9 cycles; sd_out = 4'b1111, 4'b0000, 4'b1111 alternating.
2. ch0 = +32767, ch1 = -32768 -> ch0 bit 1 on frame 1, then 0 on frames 2..101; ch1 bit 1 on every frame.
3. ch2 = +16384 for 64 frames -> ch2 shows 16 ±1 ones.
4. Hold in_valid[1]=1 through a frame -> in_ready[1]=0 exactly on SCAN index-1 cycle; a sample presented there is accepted the next cycle and used next frame.
5. run dropped during SCAN index 2 -> COMMIT still occurs, then IDLE with busy=0 and sd_out held; run re-asserted -> first strobe 9 cycles later.
6. rst_n pulsed low mid-SCAN -> sd_out=0 and busy=0 asynchronously; after release with samples 0, behaviour matches test 1 from the first frame.
